// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types for the two-port memory bus arbiter: FSM state encoding and
// requester IDs (the IDs double as the memory_mux_selector encoding).
package memory_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_CTRL = 1'b1;

endpackage

// File: rtl/memory_rr_grant.sv
// Combinational two-requester round-robin grant; lock masks out the core port.
module memory_rr_grant
   import memory_bus_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       lock,
   output logic       grant_c,
   output logic       valid_c
);

   logic [1:0] eligible;

   always_comb begin
      eligible = lock ? {req[REQ_CTRL], 1'b0} : req;
      valid_c  = |eligible;
      grant_c  = REQ_CORE;
      // On a tie the port that did not win last time goes next.
      if (eligible == 2'b11) begin
         grant_c = ~last_grant;
      end else if (eligible[REQ_CTRL]) begin
         grant_c = REQ_CTRL;
      end
   end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares one memory port between the core bus and the Interpreter bus, one
// transaction at a time, with registered strobes, read data and responses.
module memory_bus_arbiter
   import memory_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned LAT_BITS    = 4
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  core_read,
   input  logic                  core_write,
   input  logic [ADDR_WIDTH-1:0] core_address,
   input  logic [DATA_WIDTH-1:0] core_write_data,
   output logic [DATA_WIDTH-1:0] core_read_data,
   output logic                  core_response,
   input  logic                  ctrl_read,
   input  logic                  ctrl_write,
   input  logic [ADDR_WIDTH-1:0] ctrl_address,
   input  logic [DATA_WIDTH-1:0] ctrl_write_data,
   output logic [DATA_WIDTH-1:0] ctrl_read_data,
   output logic                  ctrl_response,
   input  logic                  ctrl_lock,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  memory_mux_selector
);

   state_t                state, state_d;
   logic [LAT_BITS-1:0]   lat_cnt, lat_d;
   logic                  last_grant, last_grant_d;
   logic                  sel_d, mem_read_d, mem_write_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [DATA_WIDTH-1:0] wdata_d, core_rdata_d, ctrl_rdata_d;
   logic                  core_resp_d, ctrl_resp_d;
   logic                  grant_c, grant_valid_c, grant_write_c;

   memory_rr_grant u_grant (
      .req        ({ctrl_read | ctrl_write, core_read | core_write}),
      .last_grant (last_grant),
      .lock       (ctrl_lock),
      .grant_c    (grant_c),
      .valid_c    (grant_valid_c)
   );

   always_comb begin
      state_d       = state;
      lat_d         = lat_cnt;
      last_grant_d  = last_grant;
      sel_d         = memory_mux_selector;
      mem_read_d    = mem_read;
      mem_write_d   = mem_write;
      addr_d        = mem_address;
      wdata_d       = mem_write_data;
      core_rdata_d  = core_read_data;
      ctrl_rdata_d  = ctrl_read_data;
      core_resp_d   = 1'b0;
      ctrl_resp_d   = 1'b0;
      grant_write_c = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid_c) begin
               // Both strobes set on a port is treated as a write.
               grant_write_c = (grant_c == REQ_CTRL) ? ctrl_write : core_write;
               mem_read_d    = ~grant_write_c;
               mem_write_d   = grant_write_c;
               addr_d        = (grant_c == REQ_CTRL) ? ctrl_address : core_address;
               wdata_d       = (grant_c == REQ_CTRL) ? ctrl_write_data : core_write_data;
               sel_d         = grant_c;
               lat_d         = LAT_BITS'(MEM_LATENCY - 1);
               state_d       = ACCESS;
            end
         end
         ACCESS: begin
            if (lat_cnt == '0) begin
               if (mem_read && memory_mux_selector == REQ_CTRL) ctrl_rdata_d = mem_read_data;
               if (mem_read && memory_mux_selector == REQ_CORE) core_rdata_d = mem_read_data;
               core_resp_d = (memory_mux_selector == REQ_CORE);
               ctrl_resp_d = (memory_mux_selector == REQ_CTRL);
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = RESPOND;
            end else begin
               lat_d = lat_cnt - LAT_BITS'(1);
            end
         end
         RESPOND: begin
            last_grant_d = memory_mux_selector;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= IDLE;
         lat_cnt             <= '0;
         last_grant          <= REQ_CTRL;
         memory_mux_selector <= REQ_CORE;
         mem_read            <= 1'b0;
         mem_write           <= 1'b0;
         mem_address         <= '0;
         mem_write_data      <= '0;
         core_read_data      <= '0;
         ctrl_read_data      <= '0;
         core_response       <= 1'b0;
         ctrl_response       <= 1'b0;
      end else begin
         state               <= state_d;
         lat_cnt             <= lat_d;
         last_grant          <= last_grant_d;
         memory_mux_selector <= sel_d;
         mem_read            <= mem_read_d;
         mem_write           <= mem_write_d;
         mem_address         <= addr_d;
         mem_write_data      <= wdata_d;
         core_read_data      <= core_rdata_d;
         ctrl_read_data      <= ctrl_rdata_d;
         core_response       <= core_resp_d;
         ctrl_response       <= ctrl_resp_d;
      end
   end

endmodule
